// File: rtl/alu_div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: ALU opcodes and FSM state encoding.
package alu_div_sequencer_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RSB  = 3'b010;
  localparam logic [2:0] ALU_BIC  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ORR  = 3'b101;
  localparam logic [2:0] ALU_EOR  = 3'b110;
  localparam logic [2:0] ALU_XNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_div_sequencer.sv
// Multi-cycle unsigned restoring divider that borrows the datapath ALU
// for one trial subtraction per cycle while busy.
module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic [2:0]   alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_y,
  input  logic         alu_co,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_ovf
);

  localparam int CW = $clog2(W);

  state_t          r_state;
  state_t          w_stateNext;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_d;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_quotient;
  logic [W-1:0]    r_remainder;
  logic            r_divByZero;
  logic [W-1:0]    w_remNext;
  logic [W-1:0]    w_qNext;
  logic            w_unused;

  assign w_unused = alu_n ^ alu_z ^ alu_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Abort wins over the final iteration, so an aborted run never reaches DONE.
  always_comb begin
    w_stateNext = r_state;
    alu_ctrl    = ALU_ADD;
    alu_a       = '0;
    alu_b       = '0;
    unique case (r_state)
      IDLE: begin
        if (start) w_stateNext = (divisor != '0) ? RUN : DONE;
      end
      RUN: begin
        alu_ctrl = ALU_SUB;
        alu_a    = {r_rem[W-2:0], r_q[W-1]};
        alu_b    = r_d;
        if (abort)              w_stateNext = IDLE;
        else if (r_cnt == '0)   w_stateNext = DONE;
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // A borrow means the trial subtraction failed: keep the shifted remainder.
  assign w_remNext = alu_co ? alu_a : alu_y;
  assign w_qNext   = {r_q[W-2:0], ~alu_co};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_q   <= dividend;
              r_d   <= divisor;
              r_rem <= '0;
              r_cnt <= CW'(W - 1);
            end else begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_divByZero <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!abort) begin
            r_rem <= w_remNext;
            r_q   <= w_qNext;
            if (r_cnt == '0) begin
              r_quotient  <= w_qNext;
              r_remainder <= w_remNext;
              r_divByZero <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Scoreboard bench for the divide sequencer at W=4 and W=8, each wired to a behavioural ALU.
module tb_alu_div_sequencer;
  import alu_div_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, abort4 = 1'b0;
  logic [3:0] dividend4 = '0, divisor4 = '0;
  logic       busy4, done4, dbz4, co4, n4, z4, ovf4;
  logic [3:0] quot4, rem4, a4, b4, y4;
  logic [2:0] ctrl4;
  logic [8:0] aluRes4;

  logic       start8 = 1'b0, abort8 = 1'b0;
  logic [7:0] dividend8 = '0, divisor8 = '0;
  logic       busy8, done8, dbz8, co8, n8, z8, ovf8;
  logic [7:0] quot8, rem8, a8, b8, y8;
  logic [2:0] ctrl8;
  logic [8:0] aluRes8;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  exp_t e4, e8;

  int nChecks = 0;
  int nPass = 0;
  int doneCount4 = 0;
  int doneCount8 = 0;

  alu_div_sequencer #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .dividend(dividend4), .divisor(divisor4), .busy(busy4), .done(done4),
    .quotient(quot4), .remainder(rem4), .div_by_zero(dbz4),
    .alu_ctrl(ctrl4), .alu_a(a4), .alu_b(b4), .alu_y(y4), .alu_co(co4),
    .alu_n(n4), .alu_z(z4), .alu_ovf(ovf4)
  );

  alu_div_sequencer #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
    .quotient(quot8), .remainder(rem8), .div_by_zero(dbz8),
    .alu_ctrl(ctrl8), .alu_a(a8), .alu_b(b8), .alu_y(y8), .alu_co(co8),
    .alu_n(n8), .alu_z(z8), .alu_ovf(ovf8)
  );

  // Behavioural datapath ALU; carry/borrow lands in bit W of the 9-bit result.
  function automatic logic [8:0] aluModel(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ALU_SUB:  return {1'b0, a} - {1'b0, b};
      ALU_RSB:  return {1'b0, b} - {1'b0, a};
      ALU_BIC:  return {1'b0, a & ~b};
      ALU_AND:  return {1'b0, a & b};
      ALU_ORR:  return {1'b0, a | b};
      ALU_EOR:  return {1'b0, a ^ b};
      ALU_XNOR: return {1'b0, ~(a ^ b)};
      default:  return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  always_comb begin
    aluRes4 = aluModel(ctrl4, {4'b0, a4}, {4'b0, b4});
    y4   = aluRes4[3:0];
    co4  = aluRes4[4];
    n4   = y4[3];
    z4   = (y4 == 4'd0);
    ovf4 = 1'b0;
  end

  always_comb begin
    aluRes8 = aluModel(ctrl8, a8, b8);
    y8   = aluRes8[7:0];
    co8  = aluRes8[8];
    n8   = y8[7];
    z8   = (y8 == 8'd0);
    ovf8 = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      doneCount4++;
      if (sb4.size() == 0) checkOutput("done4 unexpected", 1, 0);
      else begin
        e4 = sb4.pop_front();
        checkOutput("quot4", {28'd0, quot4}, {24'd0, e4.q});
        checkOutput("rem4", {28'd0, rem4}, {24'd0, e4.r});
        checkOutput("dbz4", {31'd0, dbz4}, {31'd0, e4.dbz});
      end
    end
    if (rst_n && done8) begin
      doneCount8++;
      if (sb8.size() == 0) checkOutput("done8 unexpected", 1, 0);
      else begin
        e8 = sb8.pop_front();
        checkOutput("quot8", {24'd0, quot8}, {24'd0, e8.q});
        checkOutput("rem8", {24'd0, rem8}, {24'd0, e8.r});
        checkOutput("dbz8", {31'd0, dbz8}, {31'd0, e8.dbz});
      end
    end
  end

  task automatic applyStimulus4(input logic [3:0] dvd, input logic [3:0] dsr,
                                input int expLat, input int expSub);
    exp_t e;
    int lat, subs;
    if (dsr == 4'd0) begin
      e.q = 8'h0F; e.r = {4'd0, dvd}; e.dbz = 1'b1;
    end else begin
      e.q = {4'd0, dvd / dsr}; e.r = {4'd0, dvd % dsr}; e.dbz = 1'b0;
    end
    sb4.push_back(e);
    dividend4 = dvd; divisor4 = dsr; start4 = 1'b1;
    lat = 0; subs = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      if (ctrl4 == ALU_SUB) subs++;
      if (done4) begin lat = n; break; end
    end
    checkOutput("latency4", lat, expLat);
    checkOutput("subcycles4", subs, expSub);
    @(posedge clk); #1;
    checkOutput("idle4 after done", {31'd0, busy4}, 0);
  endtask

  task automatic applyStimulus8(input logic [7:0] dvd, input logic [7:0] dsr, input bit interfere);
    exp_t e;
    int lat;
    e.q = dvd / dsr; e.r = dvd % dsr; e.dbz = 1'b0;
    sb8.push_back(e);
    dividend8 = dvd; divisor8 = dsr; start8 = 1'b1;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (interfere && n == 3) begin
        start8 = 1'b1; dividend8 = 8'd9; divisor8 = 8'd3;
      end
      if (done8) begin lat = n; break; end
    end
    checkOutput("latency8", lat, 9);
    @(posedge clk); #1;
  endtask

  initial begin
    int held;
    #12;
    checkOutput("reset busy4", {31'd0, busy4}, 0);
    checkOutput("reset done4", {31'd0, done4}, 0);
    checkOutput("reset quot4", {28'd0, quot4}, 0);
    checkOutput("reset ctrl4", {29'd0, ctrl4}, 0);
    checkOutput("reset busy8", {31'd0, busy8}, 0);
    checkOutput("reset rem8", {24'd0, rem8}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus4(4'd13, 4'd3, 5, 4);
    applyStimulus4(4'd15, 4'd1, 5, 4);
    applyStimulus4(4'd14, 4'd15, 5, 4);
    applyStimulus4(4'd7, 4'd0, 1, 0);

    // Abort in the second RUN cycle: no done, previous 7/0 results held.
    held = doneCount4;
    dividend4 = 4'd13; divisor4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1; abort4 = 1'b1;
    @(posedge clk); #1; abort4 = 1'b0;
    checkOutput("abort busy4", {31'd0, busy4}, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort no done4", doneCount4, held);
    checkOutput("abort held quot4", {28'd0, quot4}, 32'h0F);
    checkOutput("abort held rem4", {28'd0, rem4}, 7);
    checkOutput("abort held dbz4", {31'd0, dbz4}, 1);

    // Reset mid-run clears everything asynchronously.
    dividend4 = 4'd13; divisor4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst busy4", {31'd0, busy4}, 0);
    checkOutput("rst done4", {31'd0, done4}, 0);
    checkOutput("rst quot4", {28'd0, quot4}, 0);
    checkOutput("rst rem4", {28'd0, rem4}, 0);
    checkOutput("rst dbz4", {31'd0, dbz4}, 0);
    checkOutput("rst ctrl4", {29'd0, ctrl4}, 0);
    checkOutput("rst alu_a4", {28'd0, a4}, 0);
    checkOutput("rst alu_b4", {28'd0, b4}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post-rst busy4", {31'd0, busy4}, 0);

    applyStimulus8(8'd200, 8'd7, 1'b1);
    for (int i = 0; i < 1000; i++)
      applyStimulus8(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb4 drained", sb4.size(), 0);
    checkOutput("sb8 drained", sb8.size(), 0);
    checkOutput("done4 count", doneCount4, 4);
    checkOutput("done8 count", doneCount8, 1001);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/alu_div_sequencer.md
Name: alu_div_sequencer

Overview:
- Multi-cycle unsigned integer divider. It is the initiator side of the datapath ALU interface: it drives alu_ctrl, alu_a and alu_b, and consumes the ALU result and flags.
- It runs restoring division with one ALU subtract per cycle.
- It sits beside the datapath ALU. A small mux, owned by the datapath, gives the sequencer the ALU while busy=1.

Parameters:
- W, 4, operand and result width; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in RUN only.
- dividend  in  W  numerator, captured when start is accepted.
- divisor  in  W  denominator, captured when start is accepted.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- quotient  out  W  registered result.
- remainder  out  W  registered result.
- div_by_zero  out  1  registered flag, valid with done.
- alu_ctrl  out  3  ALU operation code; 3'b001 = A-B, 3'b000 = add (idle value).
- alu_a  out  W  ALU operand A.
- alu_b  out  W  ALU operand B.
- alu_y  in  W  ALU result.
- alu_co  in  1  ALU carry. For code 001 it is the borrow: 1 iff alu_a < alu_b, unsigned.
- alu_n, alu_z, alu_ovf  in  1 each  accepted, unused.

Behaviour:
- Reset, asynchronous, while rst_n=0: state=IDLE; busy, done, div_by_zero = 0; quotient, remainder, R, Q, D, cnt = 0; alu_ctrl=000, alu_a=0, alu_b=0.
- Reset mid-operation aborts immediately. No done is produced.
- Internal registers:
  - R, W bits: partial remainder.
  - Q, W bits: dividend shifting out / quotient shifting in.
  - D, W bits: divisor.
  - cnt, $clog2(W) bits.
- IDLE:
  - alu_ctrl=000, alu_a=0, alu_b=0.
  - start=1 and divisor!=0: Q<=dividend, D<=divisor, R<=0, cnt<=W-1, go RUN.
  - start=1 and divisor==0: quotient<=all ones, remainder<=dividend, div_by_zero<=1, go DONE.
- RUN (combinational ALU drive, result used in the same cycle):
  - alu_ctrl=001, alu_a={R[W-2:0],Q[W-1]}, alu_b=D.
  - alu_co=0: R<=alu_y, Q<={Q[W-2:0],1}.
  - alu_co=1: R<=alu_a, Q<={Q[W-2:0],0}.
  - cnt==0: load quotient and remainder from the next-state Q and R, set div_by_zero<=0, go DONE. Otherwise cnt<=cnt-1.
  - The shift never loses a bit: R is at most the consumed dividend prefix, which is < 2^W.
- abort=1 in RUN takes priority over the iteration: go IDLE. quotient, remainder and div_by_zero are unchanged, and no done is produced.
- DONE: done=1 for exactly one cycle, alu_ctrl=000, then go IDLE unconditionally. start is ignored in DONE.
- Latency:
  - Normal divide: start sampled at edge k, done high in the cycle after edge k+W. Next start is accepted at edge k+W+2.
  - Divide-by-zero: done high in the cycle after edge k.
- start while busy: ignored, no queueing; captured operands are unaffected.
- Results: quotient, remainder and div_by_zero hold until the next completed division.
- abort outside RUN: no effect.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_RSB=3'b010, ALU_BIC=3'b011, ALU_AND=3'b100, ALU_ORR=3'b101, ALU_EOR=3'b110, ALU_XNOR=3'b111.
  - State encoding: IDLE, RUN, DONE.
- Single module, no sub-module. The bench instantiates the datapath ALU with W matching and wires it to the alu_* ports.

Test Plan:
- W=4, 13/3 -> done 5 cycles after start; quotient=4, remainder=1, div_by_zero=0; alu_ctrl=001 for exactly 4 cycles.
- W=4, 15/1 -> quotient=15, remainder=0. Then 14/15 -> quotient=0, remainder=14.
- W=4, 7/0 -> done 1 cycle after start; quotient=4'hF, remainder=7, div_by_zero=1; alu_ctrl stays 000.
- W=8, 200/7 -> quotient=28, remainder=4, done 9 cycles after start. A start pulse with 9/3 mid-run is ignored and the results stay 28/4.
- W=4, abort in the 2nd RUN cycle of 13/3 -> busy low the next cycle, no done, previous results held. rst_n low mid-run -> all outputs 0 asynchronously.
- Randomized W=8: 1000 operand pairs, divisor != 0 -> quotient*divisor+remainder == dividend and remainder < divisor; each done exactly once per accepted start.
